// File: rtl/usb_pkg.sv
// Shared encodings for the low-speed USB receive front end.
//   lineState_t : classified bus state, encoded as {D+, D-}
//   rxState_t   : receive FSM states
package usb_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } lineState_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ABORT = 3'd4
  } rxState_t;

endpackage

// File: rtl/usb_line_sync.sv
// Two-flop synchronizer for the raw D+/D- pads plus line-state classifier.
// Ports:
//   useClk    in  system clock, rising edge
//   rstN      in  asynchronous active-low reset (pads read as J)
//   dPlus     in  raw D+ pad, asynchronous
//   dMinus    in  raw D- pad, asynchronous
//   lineState out synchronized line state {D+, D-}
module usb_line_sync
  import usb_pkg::*;
(
  input  logic       useClk,
  input  logic       rstN,
  input  logic       dPlus,
  input  logic       dMinus,
  output lineState_t lineState
);

  logic [1:0] padMeta_p0;
  logic [1:0] padSync_p1;

  // Stage p0: first flop may go metastable; p1: settled copy
  always_ff @(posedge useClk or negedge rstN) begin
    if (!rstN) begin
      padMeta_p0 <= LS_J;
      padSync_p1 <= LS_J;
    end else begin
      padMeta_p0 <= {dPlus, dMinus};
      padSync_p1 <= padMeta_p0;
    end
  end

  assign lineState = lineState_t'(padSync_p1);

endmodule

// File: rtl/usb_rx_nrzi_decoder.sv
// Low-speed USB receive front end: samples the synchronized line on each
// bit strobe, NRZI-decodes, detects SYNC, removes stuffed bits, assembles
// bytes LSB-first and detects EOP, SE1 and bus reset.
// Ports:
//   useClk    in   system clock, rising edge
//   rstN      in   asynchronous active-low reset
//   checkData in   one-cycle bit-time strobe
//   dPlus     in   raw D+ pad
//   dMinus    in   raw D- pad
//   rxData    out  last completed byte, first received bit in bit 0
//   rxValid   out  1-cycle pulse, rxData updated
//   rxActive  out  high from SYNC accepted until EOP, error or bus reset
//   rxEop     out  1-cycle pulse, clean byte-aligned EOP
//   rxError   out  1-cycle pulse, stuff error, SE1, misaligned or bad EOP
//   busReset  out  level, SE0 held for BUS_RESET_BITS samples or more
module usb_rx_nrzi_decoder
  import usb_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 6,
  parameter int MAX_ONES       = 6,
  parameter int BUS_RESET_BITS = 8
) (
  input  logic       useClk,
  input  logic       rstN,
  input  logic       checkData,
  input  logic       dPlus,
  input  logic       dMinus,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       rxActive,
  output logic       rxEop,
  output logic       rxError,
  output logic       busReset
);

  localparam logic [2:0] SYNC_MIN   = 3'(SYNC_MIN_ZEROS);
  localparam logic [2:0] ONES_LIMIT = 3'(MAX_ONES);
  localparam logic [7:0] RESET_RUN  = 8'(BUS_RESET_BITS);

  lineState_t lineState;

  usb_line_sync uLineSync (
    .useClk    (useClk),
    .rstN      (rstN),
    .dPlus     (dPlus),
    .dMinus    (dMinus),
    .lineState (lineState)
  );

  rxState_t   state, stateNext;
  lineState_t prevLine, prevLineNext;
  logic [2:0] zeroCnt, zeroCntNext;
  logic [2:0] onesCnt, onesCntNext;
  logic [2:0] bitCnt, bitCntNext;
  logic [1:0] se0Cnt, se0CntNext;
  logic [7:0] se0Run, se0RunNext;
  logic [7:0] shreg, shregNext;
  logic [7:0] rxDataNext;
  logic       rxValidNext, rxActiveNext, rxEopNext, rxErrorNext, busResetNext;
  logic       isJK, bitVal;

  assign isJK   = (lineState == LS_J) || (lineState == LS_K);
  // NRZI: no transition means a 1
  assign bitVal = (lineState == prevLine);

  always_comb begin
    stateNext    = state;
    prevLineNext = prevLine;
    zeroCntNext  = zeroCnt;
    onesCntNext  = onesCnt;
    bitCntNext   = bitCnt;
    se0CntNext   = se0Cnt;
    se0RunNext   = se0Run;
    shregNext    = shreg;
    rxDataNext   = rxData;
    rxValidNext  = 1'b0;
    rxEopNext    = 1'b0;
    rxErrorNext  = 1'b0;
    rxActiveNext = rxActive;
    busResetNext = busReset;

    if (checkData) begin
      if (isJK) prevLineNext = lineState;

      if (lineState == LS_SE0)
        se0RunNext = (se0Run == 8'hFF) ? se0Run : se0Run + 8'd1;
      else
        se0RunNext = 8'd0;
      busResetNext = (se0RunNext >= RESET_RUN);

      case (state)
        IDLE: begin
          if (lineState == LS_K) begin
            stateNext   = SYNC;
            zeroCntNext = 3'd1;
          end
        end

        SYNC: begin
          case (lineState)
            LS_SE0: stateNext = IDLE;
            LS_SE1: begin
              rxErrorNext = 1'b1;
              stateNext   = ABORT;
              se0CntNext  = 2'd0;
            end
            default: begin
              if (!bitVal) begin
                zeroCntNext = (zeroCnt == 3'd7) ? zeroCnt : zeroCnt + 3'd1;
              end else if (zeroCnt >= SYNC_MIN) begin
                // The SYNC's closing 1 counts toward the stuffing run
                stateNext    = DATA;
                rxActiveNext = 1'b1;
                onesCntNext  = 3'd1;
                bitCntNext   = 3'd0;
              end else begin
                stateNext = IDLE;
              end
            end
          endcase
        end

        DATA: begin
          case (lineState)
            LS_SE0: begin
              stateNext  = EOP;
              se0CntNext = 2'd1;
            end
            LS_SE1: begin
              rxErrorNext  = 1'b1;
              rxActiveNext = 1'b0;
              stateNext    = ABORT;
              se0CntNext   = 2'd0;
            end
            default: begin
              if (onesCnt == ONES_LIMIT) begin
                if (bitVal) begin
                  rxErrorNext  = 1'b1;
                  rxActiveNext = 1'b0;
                  stateNext    = ABORT;
                  se0CntNext   = 2'd0;
                end else begin
                  onesCntNext = 3'd0;
                end
              end else begin
                shregNext[bitCnt] = bitVal;
                bitCntNext        = bitCnt + 3'd1;
                onesCntNext       = bitVal ? onesCnt + 3'd1 : 3'd0;
                if (bitCnt == 3'd7) begin
                  rxDataNext  = shregNext;
                  rxValidNext = 1'b1;
                end
              end
            end
          endcase
        end

        EOP: begin
          case (lineState)
            LS_SE0: se0CntNext = (se0Cnt == 2'd3) ? se0Cnt : se0Cnt + 2'd1;
            LS_J: begin
              if (bitCnt == 3'd0) rxEopNext = 1'b1;
              else                rxErrorNext = 1'b1;
              rxActiveNext = 1'b0;
              stateNext    = IDLE;
            end
            LS_K: begin
              rxErrorNext  = 1'b1;
              rxActiveNext = 1'b0;
              stateNext    = IDLE;
            end
            default: begin
              rxErrorNext  = 1'b1;
              rxActiveNext = 1'b0;
              stateNext    = ABORT;
              se0CntNext   = 2'd0;
            end
          endcase
        end

        ABORT: begin
          // se0Cnt doubles as the "SE0 seen" flag while waiting for SE0 then J
          rxActiveNext = 1'b0;
          case (lineState)
            LS_SE0: se0CntNext = 2'd1;
            LS_J:   if (se0Cnt != 2'd0) stateNext = IDLE;
            default: se0CntNext = 2'd0;
          endcase
        end

        default: stateNext = IDLE;
      endcase

      // Bus reset overrides whatever the packet FSM decided on this sample
      if (busResetNext) begin
        stateNext    = IDLE;
        rxActiveNext = 1'b0;
        rxEopNext    = 1'b0;
        rxErrorNext  = 1'b0;
      end
    end
  end

  always_ff @(posedge useClk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      prevLine <= LS_J;
      zeroCnt  <= 3'd0;
      onesCnt  <= 3'd0;
      bitCnt   <= 3'd0;
      se0Cnt   <= 2'd0;
      se0Run   <= 8'd0;
      rxData   <= 8'd0;
      rxValid  <= 1'b0;
      rxActive <= 1'b0;
      rxEop    <= 1'b0;
      rxError  <= 1'b0;
      busReset <= 1'b0;
    end else begin
      state    <= stateNext;
      prevLine <= prevLineNext;
      zeroCnt  <= zeroCntNext;
      onesCnt  <= onesCntNext;
      bitCnt   <= bitCntNext;
      se0Cnt   <= se0CntNext;
      se0Run   <= se0RunNext;
      rxData   <= rxDataNext;
      rxValid  <= rxValidNext;
      rxActive <= rxActiveNext;
      rxEop    <= rxEopNext;
      rxError  <= rxErrorNext;
      busReset <= busResetNext;
    end
  end

  // Byte assembly register: contents only matter once bitCnt wraps
  always_ff @(posedge useClk) begin
    shreg <= shregNext;
  end

endmodule
